stl_stream_loader: RTL and testbench
====================================

Name: stl_stream_loader

Overview:
- Hardware successor to the bench-side STL loader; streams a binary STL byte stream into the CPU's 32-bit tri-port RAM B over a write port.
- Skips the 80-byte header and captures the 32-bit little-endian triangle count.
- Per 50-byte triangle record: packs vertex bytes little-endian into words, skips the 2-byte attribute, and skips or stores the 12-byte normal by mode.
- Sits between a host byte-stream source and the RAM B write port; asserts done for the CPU start sequencing.

Parameters:
- ADDR_W, 20, width of word addresses into RAM B.
- MAX_TRI, 8192, largest accepted triangle count; larger counts raise err.
- HDR_BYTES, 80, header bytes skipped before the count field.

Ports:
- CLK  in  1  clock; all state on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse. Samples keep_normal, base_addr and count_addr. Ignored while busy.
- keep_normal  in  1  1: store the normal (12 words per triangle). 0: skip it (9 words per triangle).
- base_addr  in  ADDR_W  word address of the first stored word (e.g. 0x0020B).
- count_addr  in  ADDR_W  word address that receives the triangle count (e.g. 0x00201).
- s_data  in  8  stream byte.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts the byte this cycle.
- s_last  in  1  marks the final byte of the source stream.
- m_wr_en  out  1  write request; held until accepted.
- m_wr_addr  out  ADDR_W  write word address.
- m_wr_data  out  32  write data.
- m_wr_ready  in  1  RAM accepts the write this cycle.
- busy  out  1  high from the cycle after start until done/err.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky error; cleared by the next accepted start.
- tri_count  out  32  captured triangle count; holds its value after completion.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- A byte transfers when s_valid && s_ready.
- A write completes when m_wr_en && m_wr_ready.
- s_ready = state in {HDR, CNT, NORM, VERT, ATTR} && !wr_pending.
  - A full 32-bit word stalls the input until the word is written; there is no bypass.
- Word assembly is little-endian: byte k of the group lands in bits [8k+7:8k], so the first byte is the LSB.
  - The 4th byte sets wr_pending in the same edge. m_wr_en = wr_pending.
  - wr_pending clears on the accepting edge.
- States:
  - IDLE: on start, go to HDR, clear byte counter and err, and set busy.
  - HDR: consume HDR_BYTES bytes, then go to CNT.
  - CNT: 4 bytes form the count word.
    - Write it to count_addr and load tri_count.
    - After the write is accepted: count==0 goes to DONE; count>MAX_TRI goes to ERR; otherwise go to NORM.
  - NORM: 12 bytes. If keep_normal, emit 3 words; otherwise discard. Then go to VERT.
  - VERT: 36 bytes giving 9 words (x1,y1,z1,x2,y2,z2,x3,y3,z3), then go to ATTR.
  - ATTR: 2 bytes discarded. Decrement remaining count. If remaining==0 go to DONE, else go to NORM.
  - DONE: wait until wr_pending==0, then pulse done for 1 cycle, clear busy and go to IDLE.
  - ERR: set err, clear busy, drop any pending write, go to IDLE.
- Address rule:
  - The data address starts at base_addr and increments by 1 per stored word only.
  - It wraps modulo 2^ADDR_W; wrap is not an error.
  - The count write does not advance it.
- s_last handling:
  - s_last on any accepted byte other than the final attribute byte of the last triangle goes to ERR in the following cycle.
  - With count==0, s_last on the 4th count byte is legal.
  - A missing s_last on the final byte is not an error.
  - Bytes after completion are not consumed (s_ready=0 in IDLE).
- Latency: the last word is written at the earliest on the cycle after the final VERT byte of that triangle. done follows the attribute byte by 1 cycle when no write is pending.
- Reset mid-operation returns to IDLE immediately with all outputs 0 and no further writes.
- start while busy is ignored; it neither aborts nor restarts.

Decomposition:
- Shared package stl_pkg holds:
  - state enum (IDLE, HDR, CNT, NORM, VERT, ATTR, DONE, ERR);
  - constants NORM_BYTES=12, VERT_BYTES=36, ATTR_BYTES=2, REC_BYTES=50.
- One natural sub-module: stl_word_packer (byte to 32-bit little-endian assembler with pending/ready handshake), instanced once.

Test Plan:
- count=2, keep_normal=0, base=0x0020B, count_addr=0x00201, first x1 bytes 00 00 80 3F, m_wr_ready=1 -> 0x00000002 written at 0x00201; 0x3F800000 at 0x0020B; 18 data writes ending at 0x0021C; one done pulse; tri_count=2.
- Same stream with keep_normal=1 -> 24 data writes; first normal word at 0x0020B; x1 of triangle 0 at 0x0020E.
- m_wr_ready toggled 1-of-3 cycles, s_valid random -> identical write sequence to scenario 1; s_ready low whenever m_wr_en is high and not accepted; no byte lost.
- count=0 with s_last on the 4th count byte -> single count write, done, err=0.
- count=1 with s_last on byte 20 of the record -> err=1, busy=0, no further writes. The next start clears err.
- count=MAX_TRI+1 -> count write occurs, then err=1 and no data writes.
- RESET asserted mid-VERT -> all outputs 0 immediately; a fresh start reloads correctly.

Source files
------------

// File: rtl/stl_pkg.sv
// Shared types and record geometry for the STL stream loader.
package stl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_HDR, ST_CNT, ST_NORM, ST_VERT, ST_ATTR, ST_DONE, ST_ERR
  } stl_state_t;

  localparam int CNT_BYTES  = 4;
  localparam int NORM_BYTES = 12;
  localparam int VERT_BYTES = 36;
  localparam int ATTR_BYTES = 2;
  localparam int REC_BYTES  = NORM_BYTES + VERT_BYTES + ATTR_BYTES;

endpackage

// File: rtl/stl_stream_loader_if.sv
// Byte-stream input and RAM B write port of the STL loader.
interface stl_stream_loader_if #(
  parameter int ADDR_W = 20
) ();

  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;
  logic              m_wr_en;
  logic [ADDR_W-1:0] m_wr_addr;
  logic [31:0]       m_wr_data;
  logic              m_wr_ready;

  modport master (
    input  s_data, s_valid, s_last, m_wr_ready,
    output s_ready, m_wr_en, m_wr_addr, m_wr_data
  );

  modport slave (
    output s_data, s_valid, s_last, m_wr_ready,
    input  s_ready, m_wr_en, m_wr_addr, m_wr_data
  );

endinterface

// File: rtl/stl_word_packer.sv
// Little-endian byte-to-word assembler; a full word is held pending until accepted.
module stl_word_packer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        push,
  input  logic [7:0]  byte_in,
  input  logic        flush,
  input  logic        accept,
  output logic        pending,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic        pending_q, pending_d;

  always_comb begin
    lane_d    = lane_q;
    word_d    = word_q;
    pending_d = pending_q;
    if (accept) pending_d = 1'b0;
    if (push) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_in;
      lane_d = lane_q + 2'd1;
      if (lane_q == 2'd3) pending_d = 1'b1;
    end
    // flush wins so an aborted load never leaves a stale word or lane offset
    if (flush) begin
      lane_d    = 2'd0;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      lane_q    <= 2'd0;
      word_q    <= 32'd0;
      pending_q <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      word_q    <= word_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;
  assign word    = word_q;

endmodule

// File: rtl/stl_stream_loader.sv
// Streams a binary STL image into RAM B: count word to count_addr, vertex (and optionally normal) words from base_addr.
//   state | meaning
//   IDLE  | waiting for start
//   HDR   | skipping header bytes
//   CNT   | assembling and writing the triangle count
//   NORM  | normal bytes of a record, stored or discarded by keep_normal
//   VERT  | nine vertex words of a record
//   ATTR  | attribute bytes, closes a record
//   DONE  | drain pending write, pulse done
//   ERR   | flag error, drop pending write
module stl_stream_loader
  import stl_pkg::*;
#(
  parameter int ADDR_W    = 20,
  parameter int MAX_TRI   = 8192,
  parameter int HDR_BYTES = 80
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              keep_normal,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       tri_count,
  stl_stream_loader_if.master bus
);

  stl_state_t        state_q, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [31:0]       remain_q, remain_d;
  logic [31:0]       tri_count_q, tri_count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] caddr_q, caddr_d;
  logic              keep_q, keep_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic        byte_xfer, wr_acc, pk_push, pk_flush, pk_pending, last_ok;
  logic [31:0] pk_word, cnt_word;

  stl_word_packer u_packer (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (pk_push),
    .byte_in (bus.s_data),
    .flush   (pk_flush),
    .accept  (wr_acc),
    .pending (pk_pending),
    .word    (pk_word)
  );

  assign bus.s_ready   = (state_q inside {ST_HDR, ST_CNT, ST_NORM, ST_VERT, ST_ATTR}) && !pk_pending;
  assign byte_xfer     = bus.s_valid && bus.s_ready;
  assign bus.m_wr_en   = pk_pending && (state_q != ST_ERR);
  assign wr_acc        = bus.m_wr_en && bus.m_wr_ready;
  assign bus.m_wr_addr = (state_q == ST_CNT) ? caddr_q : addr_q;
  assign bus.m_wr_data = pk_word;
  // count value as it will be once the current (4th) byte lands
  assign cnt_word      = {bus.s_data, pk_word[23:0]};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    remain_d    = remain_q;
    tri_count_d = tri_count_q;
    addr_d      = addr_q;
    caddr_d     = caddr_q;
    keep_d      = keep_q;
    busy_d      = busy_q;
    err_d       = err_q;
    pk_push     = 1'b0;
    pk_flush    = 1'b0;
    last_ok     = 1'b0;

    if (wr_acc && state_q != ST_CNT) addr_d = addr_q + ADDR_W'(1);

    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_HDR;
        cnt_d    = 7'd0;
        err_d    = 1'b0;
        busy_d   = 1'b1;
        keep_d   = keep_normal;
        addr_d   = base_addr;
        caddr_d  = count_addr;
        pk_flush = 1'b1;
      end
      ST_HDR: if (byte_xfer) begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(HDR_BYTES - 1)) begin
          cnt_d   = 7'd0;
          state_d = ST_CNT;
        end
      end
      ST_CNT: begin
        if (byte_xfer) begin
          pk_push = 1'b1;
          cnt_d   = cnt_q + 7'd1;
          if (cnt_q == 7'(CNT_BYTES - 1)) begin
            tri_count_d = cnt_word;
            remain_d    = cnt_word;
            last_ok     = (cnt_word == 32'd0);
          end
        end
        if (wr_acc) begin
          cnt_d = 7'd0;
          if (tri_count_q == 32'd0)                state_d = ST_DONE;
          else if (tri_count_q > 32'(MAX_TRI))     state_d = ST_ERR;
          else                                     state_d = ST_NORM;
        end
      end
      // cnt_q runs across the whole record in NORM/VERT/ATTR
      ST_NORM: if (byte_xfer) begin
        pk_push = keep_q;
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == 7'(NORM_BYTES - 1)) state_d = ST_VERT;
      end
      ST_VERT: if (byte_xfer) begin
        pk_push = 1'b1;
        cnt_d   = cnt_q + 7'd1;
        if (cnt_q == 7'(NORM_BYTES + VERT_BYTES - 1)) state_d = ST_ATTR;
      end
      ST_ATTR: if (byte_xfer) begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(REC_BYTES - 1)) begin
          cnt_d    = 7'd0;
          remain_d = remain_q - 32'd1;
          last_ok  = (remain_q == 32'd1);
          state_d  = (remain_q == 32'd1) ? ST_DONE : ST_NORM;
        end
      end
      ST_DONE: if (!pk_pending) begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_d    = 1'b1;
        busy_d   = 1'b0;
        pk_flush = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (byte_xfer && bus.s_last && !last_ok) state_d = ST_ERR;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 7'd0;
      remain_q    <= 32'd0;
      tri_count_q <= 32'd0;
      addr_q      <= '0;
      caddr_q     <= '0;
      keep_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remain_q    <= remain_d;
      tri_count_q <= tri_count_d;
      addr_q      <= addr_d;
      caddr_q     <= caddr_d;
      keep_q      <= keep_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign done      = (state_q == ST_DONE) && !pk_pending;
  assign busy      = busy_q;
  assign err       = err_q;
  assign tri_count = tri_count_q;

endmodule

// File: tb/tb_stl_stream_loader.sv
// Scoreboard bench for stl_stream_loader: expected RAM B writes are modelled from each generated stream.
module tb_stl_stream_loader;

  localparam int ADDR_W  = 20;
  localparam int MAX_TRI = 8192;

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic        keep_normal = 1'b0;
  logic [19:0] base_addr = '0;
  logic [19:0] count_addr = '0;
  logic        busy, done, err;
  logic [31:0] tri_count;

  stl_stream_loader_if #(.ADDR_W(ADDR_W)) bus_if ();

  stl_stream_loader #(.ADDR_W(ADDR_W), .MAX_TRI(MAX_TRI), .HDR_BYTES(80)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .start       (start),
    .keep_normal (keep_normal),
    .base_addr   (base_addr),
    .count_addr  (count_addr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .tri_count   (tri_count),
    .bus         (bus_if)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_done = 0;
  int          n_extra = 0;
  int          wr_mode = 0;
  int          cyc = 0;
  logic [7:0]  stm[$];
  wr_t         exp_q[$];
  logic [19:0] log_addr[$];
  logic [31:0] log_data[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    bus_if.m_wr_ready = 1'b1;
    forever begin
      @(negedge CLK);
      cyc++;
      bus_if.m_wr_ready = (wr_mode == 0) ? 1'b1 : (cyc % 3 == 0);
    end
  end

  // write monitor: pops the scoreboard on every accepted write
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET === 1'b1 && bus_if.m_wr_en === 1'b1) begin
        chk("sready_while_wr", bus_if.s_ready, 0);
        if (bus_if.m_wr_ready) begin
          log_addr.push_back(bus_if.m_wr_addr);
          log_data.push_back(bus_if.m_wr_data);
          if (exp_q.size() == 0) n_extra++;
          else begin
            e = exp_q.pop_front();
            chk("wr", {12'h0, bus_if.m_wr_addr, bus_if.m_wr_data}, {12'h0, e.addr, e.data});
          end
        end
      end
      if (done === 1'b1) n_done++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // builds the byte stream and the writes it must produce; cut>=0 truncates after byte cut
  task automatic build(input int unsigned cnt, input bit keep, input logic [19:0] base,
                       input logic [19:0] caddr, input int ntri, input int cut);
    logic [31:0] acc, x1, cw;
    logic [19:0] a;
    logic [7:0]  b;
    stm.delete(); exp_q.delete(); log_addr.delete(); log_data.delete();
    n_extra = 0;
    x1 = 32'h3F80_0000;
    cw = cnt;
    a = base;
    acc = '0;
    for (int i = 0; i < 80; i++) stm.push_back(8'(i * 3 + 7));
    for (int k = 0; k < 4; k++) stm.push_back(cw[8*k +: 8]);
    exp_q.push_back(wr_t'({caddr, cw}));
    for (int t = 0; t < ntri; t++) begin
      for (int j = 0; j < 50; j++) begin
        if (t == 0 && j >= 12 && j < 16) b = x1[8*(j-12) +: 8];
        else b = 8'(t * 37 + j * 5 + 1);
        stm.push_back(b);
        if ((j < 12 && keep) || (j >= 12 && j < 48)) begin
          acc[8*(j%4) +: 8] = b;
          if (j % 4 == 3) begin
            if (cut < 0 || stm.size() - 1 < cut) exp_q.push_back(wr_t'({a, acc}));
            a = a + 20'd1;
          end
        end
      end
    end
    if (cut >= 0) while (stm.size() > cut + 1) void'(stm.pop_back());
  endtask

  task automatic do_start(input bit keep, input logic [19:0] base, input logic [19:0] caddr);
    @(negedge CLK);
    start = 1'b1; keep_normal = keep; base_addr = base; count_addr = caddr;
    @(negedge CLK);
    start = 1'b0; keep_normal = ~keep; base_addr = '0; count_addr = '0;
    #1;
    chk("busy_after_start", busy, 1);
    chk("err_after_start", err, 0);
  endtask

  task automatic run(input int last_idx, input int nbytes, input int vpct);
    int idx = 0;
    int c = 0;
    while (idx < nbytes && c < 20000) begin
      @(negedge CLK);
      bus_if.s_valid = ($urandom_range(99) < vpct);
      bus_if.s_data  = stm[idx];
      bus_if.s_last  = (idx == last_idx);
      #1;
      if (bus_if.s_valid && bus_if.s_ready) idx++;
      c++;
    end
    chk("stream_consumed", idx, nbytes);
    @(negedge CLK);
    bus_if.s_valid = 1'b0;
    bus_if.s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy === 1'b1 && c < 5000) begin
      @(negedge CLK);
      c++;
    end
    chk("idle_in_time", busy, 0);
    repeat (5) @(negedge CLK);
  endtask

  task automatic end_checks(input string tag, input int n0, input int exp_done, input int exp_nwr,
                            input logic exp_err, input logic [31:0] exp_tc);
    chk({tag, "_done"}, n_done - n0, exp_done);
    chk({tag, "_nwr"}, log_addr.size(), exp_nwr);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_tri_count"}, tri_count, exp_tc);
    chk({tag, "_sb_left"}, exp_q.size(), 0);
    chk({tag, "_extra_wr"}, n_extra, 0);
    chk({tag, "_idle_sready"}, bus_if.s_ready, 0);
  endtask

  task automatic scen_basic(input string tag);
    int n0;
    build(2, 0, 20'h0020B, 20'h00201, 2, -1);
    do_start(0, 20'h0020B, 20'h00201);
    n0 = n_done;
    run(stm.size() - 1, stm.size(), 100);
    wait_idle();
    end_checks(tag, n0, 1, 19, 0, 32'd2);
    chk({tag, "_cnt_wr"}, {log_addr[0], log_data[0]}, {20'h00201, 32'd2});
    chk({tag, "_x1_wr"}, {log_addr[1], log_data[1]}, {20'h0020B, 32'h3F80_0000});
    chk({tag, "_last_addr"}, log_addr[18], 20'h0021C);
  endtask

  initial begin
    int n0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_last  = 1'b0;

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_s_ready", bus_if.s_ready, 0);
    chk("rst_m_wr_en", bus_if.m_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_tri_count", tri_count, 0);
    RESET = 1'b1;

    scen_basic("s1");

    // keep_normal plus a start pulse while busy, which must be ignored
    build(2, 1, 20'h0020B, 20'h00201, 2, -1);
    do_start(1, 20'h0020B, 20'h00201);
    n0 = n_done;
    fork
      run(stm.size() - 1, stm.size(), 100);
      begin
        repeat (100) @(negedge CLK);
        start = 1'b1; keep_normal = 1'b0; base_addr = 20'h00100;
        @(negedge CLK);
        start = 1'b0;
      end
    join
    wait_idle();
    end_checks("s2", n0, 1, 25, 0, 32'd2);
    chk("s2_norm0_addr", log_addr[1], 20'h0020B);
    chk("s2_x1_wr", {log_addr[4], log_data[4]}, {20'h0020E, 32'h3F80_0000});
    chk("s2_last_addr", log_addr[24], 20'h00222);

    // write back-pressure and bursty input
    wr_mode = 1;
    build(2, 0, 20'h0020B, 20'h00201, 2, -1);
    do_start(0, 20'h0020B, 20'h00201);
    n0 = n_done;
    run(stm.size() - 1, stm.size(), 50);
    wait_idle();
    end_checks("s3", n0, 1, 19, 0, 32'd2);
    wr_mode = 0;

    // address wrap at the top of the word space
    build(1, 0, 20'hFFFFC, 20'h00201, 1, -1);
    do_start(0, 20'hFFFFC, 20'h00201);
    n0 = n_done;
    run(stm.size() - 1, stm.size(), 100);
    wait_idle();
    end_checks("s4", n0, 1, 10, 0, 32'd1);
    chk("s4_wrap_addr", log_addr[5], 20'h00000);
    chk("s4_last_addr", log_addr[9], 20'h00004);

    // empty model, s_last on the last count byte
    build(0, 0, 20'h0020B, 20'h00201, 0, -1);
    do_start(0, 20'h0020B, 20'h00201);
    n0 = n_done;
    run(83, 84, 100);
    wait_idle();
    end_checks("s5", n0, 1, 1, 0, 32'd0);

    // premature s_last inside the vertex block
    build(1, 0, 20'h0020B, 20'h00201, 1, 104);
    do_start(0, 20'h0020B, 20'h00201);
    n0 = n_done;
    run(104, 105, 100);
    wait_idle();
    repeat (20) @(negedge CLK);
    end_checks("s6", n0, 0, 3, 1, 32'd1);

    // count above MAX_TRI; start also clears the previous err
    build(MAX_TRI + 1, 0, 20'h0020B, 20'h00201, 0, -1);
    do_start(0, 20'h0020B, 20'h00201);
    n0 = n_done;
    run(-1, 84, 100);
    wait_idle();
    end_checks("s7", n0, 0, 1, 1, 32'(MAX_TRI + 1));

    // reset in the middle of the vertex block, then a clean reload
    build(2, 0, 20'h0020B, 20'h00201, 2, -1);
    do_start(0, 20'h0020B, 20'h00201);
    run(-1, 106, 100);
    RESET = 1'b0;
    #1;
    chk("mid_rst_s_ready", bus_if.s_ready, 0);
    chk("mid_rst_m_wr_en", bus_if.m_wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_tri_count", tri_count, 0);
    exp_q.delete();
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    scen_basic("s8");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
